// File: rtl/add_seq_ctrl.sv
// Multi-precision adder sequencer: adds two NBYTES-byte operands with one shared 8-bit adder, one byte per clock, LSB first.
// Optional subtract mode via ADD_SEQ_SUB_EN (adds the 'sub' input port).

module full_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    // 9-bit sum keeps the carry out of bit 7
    logic [8:0] total;

    assign total = 9'(a) + 9'(b) + 9'(ci);
    assign s     = total[7:0];
    assign co    = total[8];
endmodule

module add_seq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
);
    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned LAST = NBYTES - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry;
    logic [IW-1:0]   idx;

    logic [7:0]      add_a;
    logic [7:0]      add_b;
    logic [7:0]      add_s;
    logic            add_co;

    // Byte slice currently being processed
    assign add_a = a_reg[{idx, 3'b000} +: 8];
    assign add_b = b_reg[{idx, 3'b000} +: 8];

    full_adder_8bit u_add (
        .a  (add_a),
        .b  (add_b),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
`ifdef ADD_SEQ_SUB_EN
                        // Subtract as a + ~b + 1; cout=1 then means no borrow
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
`else
                        b_reg <= b;
                        carry <= cin;
`endif
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[{idx, 3'b000} +: 8] <= add_s;
                    carry                   <= add_co;
                    if (idx == IW'(LAST)) begin
                        cout  <= add_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (NBYTES=4): table-driven operations plus
// hand sequences for hold, ignored starts and mid-operation reset.

module tb_add_seq_ctrl;
    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
`ifdef ADD_SEQ_SUB_EN
    logic          sub;
`endif
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;

    int n_checks = 0;
    int n_pass   = 0;

    add_seq_ctrl #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef ADD_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check latency, busy width, single done pulse and result
    task automatic run_op(input vec_t v, input string name);
        int cycles;
        int busy_cnt;
        bit seen;
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
`ifdef ADD_SEQ_SUB_EN
        sub   = v.sub;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles   = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            cycles++;
            tick();
        end
        check({name, " done_seen"}, 64'(seen), 64'd1);
        check({name, " latency"}, 64'(cycles), 64'(NB));
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(NB));
        check({name, " sum"}, 64'(sum), 64'(v.exp_sum));
        check({name, " cout"}, 64'(cout), 64'(v.exp_cout));
        tick();
        check({name, " done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        vec_t v;
        int dones;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        sub   = 1'b0;
`endif

        vecs.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1});
`ifdef ADD_SEQ_SUB_EN
        vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1});
        vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_000D, 1'b0});
`endif

        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset sum", 64'(sum), 64'd0);
        check("reset cout", 64'(cout), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Result must hold through idle cycles
        run_op(vecs[2], "hold_op");
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold sum c%0d", i), 64'(sum), 64'h0000_0000_ACF1_3568);
            check($sformatf("hold cout c%0d", i), 64'({cout, done, busy}), 64'd0);
        end

        // Starts during RUN and DONE are ignored
        a     = 32'h1;
        b     = 32'h1;
        cin   = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        sub   = 1'b0;
`endif
        start = 1'b1;
        tick();
        a     = 32'hFFFF_FFFF;
        dones = 0;
        for (int i = 0; i < 40 && dones == 0; i++) begin
            if (done) dones++;
            else tick();
        end
        check("ignore done_seen", 64'(dones), 64'd1);
        check("ignore sum", 64'(sum), 64'h2);
        tick();
        start = 1'b0;
        check("ignore after_done busy", 64'({busy, done}), 64'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dones++;
            tick();
        end
        check("ignore no_second_op", 64'(dones), 64'd0);
        check("ignore sum_hold", 64'(sum), 64'h2);

        // Asynchronous reset in the middle of RUN
        a     = 32'hFFFF_FFFF;
        b     = 32'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midrst busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst sum", 64'(sum), 64'd0);
        check("midrst cout", 64'(cout), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        v = '{32'h3, 32'h4, 1'b0, 1'b0, 32'h7, 1'b0};
        run_op(v, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
